// File: rtl/score_counter_bank_if.sv
// Bus between the ball/video logic and the score keeper. The video side
// drives the master modport and the score bank takes the slave modport.
interface score_counter_bank_if #(
    parameter int unsigned PLAYERS = 2,
    parameter int unsigned DIGITS  = 2
);
    logic                        _attract;
    logic                        _hvid;
    logic                        hblank;
    logic [PLAYERS-1:0]          side;
    logic [1:0]                  win_sel;
    logic                        _miss;
    logic                        score_evt;
    logic                        stop_g;
    logic [PLAYERS-1:0]          winner;
    logic [PLAYERS*DIGITS*4-1:0] score;

    modport master (
        output _attract, _hvid, hblank, side, win_sel,
        input  _miss, score_evt, stop_g, winner, score
    );

    modport slave (
        input  _attract, _hvid, hblank, side, win_sel,
        output _miss, score_evt, stop_g, winner, score
    );
endinterface

// File: rtl/score_counter_bank.sv
// Synchronous N-player BCD score keeper: detects misses on blanking entry,
// credits flagged players, and ends the game at a DIP-selected threshold.
module score_counter_bank #(
    parameter int unsigned PLAYERS = 2,
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned WIN_A   = 11,
    parameter int unsigned WIN_B   = 15,
    parameter int unsigned WIN_C   = 21
) (
    input  logic                 clk,
    input  logic                 _reset,
    input  logic                 srst,
    score_counter_bank_if.slave  bus
);
    localparam int unsigned SW = DIGITS * 4;
    localparam int unsigned TW = SW + 4;
    localparam logic [SW-1:0] MAX_BCD = {DIGITS{4'h9}};

    // Thresholds carry one spare digit so values beyond the score range never match.
    function automatic logic [TW-1:0] to_bcd(input int unsigned v);
        logic [TW-1:0] res;
        int unsigned   r;
        res = '0;
        r   = v;
        for (int unsigned i = 0; i < DIGITS + 1; i++) begin
            res[i*4 +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [TW-1:0] THR_A = to_bcd(WIN_A);
    localparam logic [TW-1:0] THR_B = to_bcd(WIN_B);
    localparam logic [TW-1:0] THR_C = to_bcd(WIN_C);

    logic                   miss_raw;
    logic                   miss_q;
    logic                   miss_d;
    logic                   detect;
    logic                   miss_n_q;
    logic                   evt_q;
    logic                   stop_g;
    logic                   limit_en;
    logic [TW-1:0]          thr;
    logic [PLAYERS-1:0]     inc_en;
    logic [PLAYERS-1:0]     win_now;
    logic [PLAYERS-1:0]     winner_q;
    logic [PLAYERS*SW-1:0]  score_q;

    assign miss_raw = ~bus._hvid & bus.hblank & bus._attract;
    assign detect   = miss_q & ~miss_d;
    assign stop_g   = |winner_q;
    assign limit_en = (bus.win_sel != 2'b11);

    always_comb begin
        case (bus.win_sel)
            2'b00:   thr = THR_A;
            2'b01:   thr = THR_B;
            2'b10:   thr = THR_C;
            default: thr = '1;
        endcase
    end

    // BCD digits order like binary, so a plain magnitude compare is exact.
    always_comb begin
        inc_en  = '0;
        win_now = '0;
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            inc_en[p]  = detect & bus.side[p] & ~stop_g & ~srst &
                         (score_q[p*SW +: SW] != MAX_BCD);
            win_now[p] = limit_en & ({4'h0, score_q[p*SW +: SW]} >= thr);
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            miss_q   <= 1'b0;
            miss_d   <= 1'b0;
            miss_n_q <= 1'b1;
            evt_q    <= 1'b0;
            winner_q <= '0;
            score_q  <= '0;
        end else begin
            miss_q   <= miss_raw;
            miss_d   <= miss_q;
            miss_n_q <= ~detect;
            evt_q    <= |inc_en;
            if (srst) begin
                score_q  <= '0;
                winner_q <= '0;
            end else begin
                for (int unsigned p = 0; p < PLAYERS; p++) begin
                    if (inc_en[p]) begin
                        score_q[p*SW +: SW] <= bcd_inc(score_q[p*SW +: SW]);
                    end
                end
                winner_q <= win_now;
            end
        end
    end

    assign bus._miss     = miss_n_q;
    assign bus.score_evt = evt_q;
    assign bus.stop_g    = stop_g;
    assign bus.winner    = winner_q;
    assign bus.score     = score_q;
endmodule
